alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1, operation offered.
REQ-004 SHALL have port in_ready, output, 1, unit can accept an operation this cycle.
REQ-005 SHALL have port alu_ctrl, input, 4, operation code from the ALU control decoder.
REQ-006 SHALL have port op_a, input, 32, first operand (rs1).
REQ-007 SHALL have port op_b, input, 32, second operand (rs2 or immediate); bits [4:0] are the shift amount.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port result, output, 32, operation result.
REQ-011 SHALL have port zero, output, 1, high when result == 0; used for branch resolution.

Function
REQ-012 SHALL decode alu_ctrl as: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 XOR, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1001 SRA; any other code executes as ADD.
REQ-013 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 SHALL drive in_ready = (state == IDLE) or (state == DONE and out_ready), combinationally.
REQ-015 SHALL accept an operation on a rising edge where in_valid and in_ready are both high, capturing alu_ctrl, op_a and op_b[4:0].
REQ-016 SHALL, for non-shift codes, register the result on the accept edge and enter DONE, so out_valid rises one cycle after accept.
REQ-017 SHALL, for shift codes with shamt 0, register op_a unchanged and enter DONE (1-cycle latency).
REQ-018 SHALL, for shift codes with shamt N > 0, load op_a into the result register and N into a 5-bit counter, then enter SHIFT.
REQ-019 In SHIFT, the unit SHALL shift the result register 1 bit per cycle and decrement the counter; it SHALL enter DONE on the edge the counter goes 1 -> 0, so out_valid rises N+1 cycles after accept.
REQ-020 SHALL fill shifts as: SLL with 0 at the LSB, SRL with 0 at the MSB, SRA with a copy of bit 31.
REQ-021 SHALL perform ADD/SUB modulo 2^32 with no overflow flag; SLT/SLTU SHALL return 32'h1 or 32'h0.
REQ-022 SHALL hold out_valid, result and zero stable in DONE while out_ready is low.
REQ-023 In DONE with out_ready high and no accept, the unit SHALL return to IDLE and drop out_valid on the next edge.
REQ-024 In DONE with out_ready and in_valid both high, the unit SHALL retire the current result and accept the new operation on the same edge; out_valid stays high for a non-shift or shamt-0 op, and drops for an N > 0 shift.
REQ-025 SHALL ignore in_valid, alu_ctrl and operand changes while in SHIFT.
REQ-026 SHALL compute zero from the registered result; it SHALL be valid only while out_valid is high.

Reset
REQ-027 On any edge with rst high, the unit SHALL go to IDLE and clear result to 0, counter to 0 and out_valid to 0, regardless of state.
REQ-028 rst SHALL take priority over every handshake, including in mid-SHIFT; any partial operation is discarded.
REQ-029 After rst deasserts, in_ready SHALL be 1 and out_valid 0.

Verification
REQ-030 ADD: ctrl 0010, a=32'h0000_0005, b=32'h0000_0003, out_ready=1 -> one cycle later out_valid=1, result=8, zero=0; next cycle IDLE.
REQ-031 SUB to zero, then back-pressure: ctrl 0110, a=b=32'h1234_5678, out_ready=0 for 3 cycles -> result=0 and zero=1 held stable; in_ready=0 throughout; retire when out_ready=1.
REQ-032 SRA: ctrl 1001, a=32'h8000_0000, b=4 -> out_valid 5 cycles after accept, result=32'hF800_0000; SLL with a=1, b=31 -> result=32'h8000_0000 after 32 cycles.
REQ-033 SLT/SLTU: a=32'hFFFF_FFFF, b=1 -> SLT gives 1; SLTU gives 0; undefined code 1111 with a=2, b=3 -> 5.
REQ-034 Back-to-back: in_valid held high with XOR (a=32'hF0F0_F0F0, b=32'hFFFF_FFFF) followed by OR, out_ready=1 -> results 32'h0F0F_0F0F then OR result on consecutive cycles, out_valid continuously high.
REQ-035 Reset in mid-shift: SRL of b=20 accepted, rst pulsed at cycle 7 -> next edge out_valid=0, result=0, in_ready=1; no stale result appears afterward.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic ops and iterative
// 1-bit-per-cycle shifter, with valid/ready handshakes on input and output.
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_ctrl,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [CTRL_W-1:0] CTRL_AND  = 4'b0000;
    localparam logic [CTRL_W-1:0] CTRL_OR   = 4'b0001;
    localparam logic [CTRL_W-1:0] CTRL_ADD  = 4'b0010;
    localparam logic [CTRL_W-1:0] CTRL_SLL  = 4'b0011;
    localparam logic [CTRL_W-1:0] CTRL_XOR  = 4'b0100;
    localparam logic [CTRL_W-1:0] CTRL_SRL  = 4'b0101;
    localparam logic [CTRL_W-1:0] CTRL_SUB  = 4'b0110;
    localparam logic [CTRL_W-1:0] CTRL_SLT  = 4'b0111;
    localparam logic [CTRL_W-1:0] CTRL_SLTU = 4'b1000;
    localparam logic [CTRL_W-1:0] CTRL_SRA  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_kind_t;

    state_t              state;
    shift_kind_t         sh_kind;
    logic [SHAMT_W-1:0]  cnt;
    logic [DATA_W-1:0]   result_q;
    logic                zero_q;
    logic                out_valid_q;

    logic                accept;
    logic                is_shift;
    logic [SHAMT_W-1:0]  shamt;
    shift_kind_t         sh_kind_in;
    logic                slt_bit;
    logic                sltu_bit;
    logic [DATA_W-1:0]   alu_res;
    logic [DATA_W-1:0]   shift_next;

    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

    // Ready when idle, or when the held result is being retired this cycle
    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = op_b[SHAMT_W-1:0];

    // Decode shift class and compute the single-cycle result for the offered op
    always_comb begin
        is_shift   = 1'b0;
        sh_kind_in = SH_LL;
        slt_bit    = $signed(op_a) < $signed(op_b);
        sltu_bit   = op_a < op_b;
        alu_res    = op_a + op_b;
        case (alu_ctrl)
            CTRL_AND:  alu_res = op_a & op_b;
            CTRL_OR:   alu_res = op_a | op_b;
            CTRL_ADD:  alu_res = op_a + op_b;
            CTRL_XOR:  alu_res = op_a ^ op_b;
            CTRL_SUB:  alu_res = op_a - op_b;
            CTRL_SLT:  alu_res = {{(DATA_W-1){1'b0}}, slt_bit};
            CTRL_SLTU: alu_res = {{(DATA_W-1){1'b0}}, sltu_bit};
            CTRL_SLL: begin
                is_shift   = 1'b1;
                sh_kind_in = SH_LL;
                alu_res    = op_a;
            end
            CTRL_SRL: begin
                is_shift   = 1'b1;
                sh_kind_in = SH_RL;
                alu_res    = op_a;
            end
            CTRL_SRA: begin
                is_shift   = 1'b1;
                sh_kind_in = SH_RA;
                alu_res    = op_a;
            end
            default:   alu_res = op_a + op_b;
        endcase
    end

    // One-bit shift step of the result register for the captured shift kind
    always_comb begin
        shift_next = result_q;
        case (sh_kind)
            SH_LL:   shift_next = {result_q[DATA_W-2:0], 1'b0};
            SH_RL:   shift_next = {1'b0, result_q[DATA_W-1:1]};
            SH_RA:   shift_next = {result_q[DATA_W-1], result_q[DATA_W-1:1]};
            default: shift_next = result_q;
        endcase
    end

    // Control FSM with result, counter and output-valid registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            sh_kind     <= SH_LL;
            cnt         <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (is_shift && (shamt != '0)) begin
                            result_q    <= op_a;
                            zero_q      <= (op_a == '0);
                            cnt         <= shamt;
                            sh_kind     <= sh_kind_in;
                            out_valid_q <= 1'b0;
                            state       <= ST_SHIFT;
                        end else begin
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            out_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end else if ((state == ST_DONE) && out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    result_q <= shift_next;
                    zero_q   <= (shift_next == '0);
                    cnt      <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, hand-written
// handshake/reset sequences and a randomized scoreboard run.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_cmp;
    int n_bad;

    alu_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: whole-word arithmetic straight from the opcode table
    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = int'(b[4:0]);
        case (c)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd3: return a << sh;
            4'd4: return a ^ b;
            4'd5: return a >> sh;
            4'd6: return a - b;
            4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: return (a < b) ? 32'd1 : 32'd0;
            4'd9: return $unsigned($signed(a) >>> sh);
            default: return a + b;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
        if ((c == 4'd3 || c == 4'd5 || c == 4'd9) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        alu_ctrl  = v.ctrl;
        op_a      = v.a;
        op_b      = v.b;
        out_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_result", idx), result, v.res);
        chk($sformatf("v%0d_zero", idx), 32'(zero), 32'(v.res == 32'd0));
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_idle_after", idx), 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] q [$];
        logic        have_offer;
        logic        stall_prev;
        logic [31:0] res_prev;
        int          guard;

        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{4'b0010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1};
        vecs[1]  = '{4'b0110, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1};
        vecs[2]  = '{4'b1001, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5};
        vecs[3]  = '{4'b0011, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32};
        vecs[4]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
        vecs[5]  = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
        vecs[6]  = '{4'b1111, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1};
        vecs[7]  = '{4'b0000, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1};
        vecs[8]  = '{4'b0100, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1};
        vecs[9]  = '{4'b0101, 32'h8000_0000, 32'h0000_0023, 32'h1000_0000, 4};
        vecs[10] = '{4'b1001, 32'h8000_0001, 32'h0000_0020, 32'h8000_0001, 1};
        vecs[11] = '{4'b0101, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 5};
        vecs[12] = '{4'b0001, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1};
        vecs[13] = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_ctrl  = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'd0);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // SUB to zero held under back-pressure
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 4'b0110; op_a = 32'h1234_5678; op_b = 32'h1234_5678;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_result", result, 32'd0);
            chk("bp_zero", 32'(zero), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_retired", 32'(out_valid), 32'd0);

        // Back-to-back XOR, OR, then a shift accepted from DONE
        in_valid = 1'b1; alu_ctrl = 4'b0100; op_a = 32'hF0F0_F0F0; op_b = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        alu_ctrl = 4'b0001; op_a = 32'h00FF_0000; op_b = 32'h0000_FF00;
        #1;
        chk("b2b_xor_valid", 32'(out_valid), 32'd1);
        chk("b2b_xor_result", result, 32'h0F0F_0F0F);
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        alu_ctrl = 4'b0011; op_a = 32'h0000_0003; op_b = 32'h0000_0002;
        #1;
        chk("b2b_or_valid", 32'(out_valid), 32'd1);
        chk("b2b_or_result", result, 32'h00FF_FF00);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_shift_drop", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_shift_wait", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_shift_valid", 32'(out_valid), 32'd1);
        chk("b2b_shift_result", result, 32'h0000_000C);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle", 32'(out_valid), 32'd0);

        // Reset in the middle of a long SRL
        in_valid = 1'b1; alu_ctrl = 4'b0101; op_a = 32'hFFFF_FFFF; op_b = 32'd20;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd1; op_b = 32'd1;
        #1;
        chk("shift_ignores_input", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        begin
            logic stale;
            stale = 1'b0;
            repeat (30) begin
                @(negedge clk);
                if (out_valid) stale = 1'b1;
            end
            chk("rst_mid_no_stale", 32'(stale), 32'd0);
        end

        // Randomized traffic against the scoreboard
        have_offer = 1'b0;
        stall_prev = 1'b0;
        res_prev   = 32'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!have_offer && ($urandom_range(0, 2) != 0)) begin
                have_offer = 1'b1;
                alu_ctrl   = 4'($urandom_range(0, 15));
                op_a       = $urandom;
                op_b       = $urandom;
                if ($urandom_range(0, 7) == 0) op_b = op_a;
                if ($urandom_range(0, 7) == 0) op_b = {27'($urandom), 5'd0};
            end else if (!have_offer) begin
                op_a = $urandom;
                op_b = $urandom;
            end
            in_valid  = have_offer;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (stall_prev) begin
                chk("rnd_hold_valid", 32'(out_valid), 32'd1);
                chk("rnd_hold_result", result, res_prev);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    logic [31:0] e;
                    e = q.pop_front();
                    chk("rnd_result", result, e);
                    chk("rnd_zero", 32'(zero), 32'(e == 32'd0));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(alu_ctrl, op_a, op_b));
                have_offer = 1'b0;
                if (model_lat(alu_ctrl, op_b) < 1) n_bad++;
            end
            stall_prev = out_valid && !out_ready;
            res_prev   = result;
        end

        // Drain whatever is still in flight
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 64) begin
            #1;
            if (out_valid) begin
                logic [31:0] e;
                e = q.pop_front();
                chk("drain_result", result, e);
            end
            @(negedge clk);
            guard++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
